// File: rtl/goose_jump_ctrl.sv
// goose_jump_ctrl
// Turns a player jump request into a tick-paced vertical trajectory for the
// goose sprite. The trajectory runs rise, hold at apex, fall, land. While the
// goose is on the ground, each tick toggles the running-leg frame.
//
// Ports:
//   clk_in     system clock; all logic on posedge
//   reset      synchronous, active-high reset
//   tick       one-cycle strobe from the clock divider; motion advances only on it
//   jump_req   jump request; sampled every cycle, honoured only when grounded
//   height     registered height above ground, in pixels
//   airborne   high whenever the goose is not on the ground
//   landed     one-cycle pulse on the cycle after touchdown
//   leg_frame  registered leg animation frame
module goose_jump_ctrl #(
    parameter int HEIGHT_W   = 7,
    parameter int MAX_HEIGHT = 64,
    parameter int RISE_STEP  = 8,
    parameter int FALL_STEP  = 4,
    parameter int HOLD_TICKS = 4
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                tick,
    input  logic                jump_req,
    output logic [HEIGHT_W-1:0] height,
    output logic                airborne,
    output logic                landed,
    output logic                leg_frame
);

    localparam int HC_W     = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int FIRST    = (RISE_STEP < MAX_HEIGHT) ? RISE_STEP : MAX_HEIGHT;

    localparam logic [HEIGHT_W-1:0] MAX_H     = HEIGHT_W'(MAX_HEIGHT);
    localparam logic [HEIGHT_W-1:0] FIRST_H   = HEIGHT_W'(FIRST);
    localparam logic [HC_W-1:0]     LAST_HOLD = HC_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        HOLD   = 2'd2,
        FALL   = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [HEIGHT_W-1:0] height_d;
    logic [HC_W-1:0]     hold_cnt, hold_d;
    logic                pending, pending_d;
    logic                leg_d, landed_d;
    logic [HEIGHT_W:0]   rise_sum;

    // One extra bit so the apex test cannot be fooled by wrap-around.
    assign rise_sum = {1'b0, height} + (HEIGHT_W+1)'(RISE_STEP);
    assign airborne = (state != GROUND);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= GROUND;
            height    <= '0;
            hold_cnt  <= '0;
            pending   <= 1'b0;
            leg_frame <= 1'b0;
            landed    <= 1'b0;
        end else begin
            state     <= state_d;
            height    <= height_d;
            hold_cnt  <= hold_d;
            pending   <= pending_d;
            leg_frame <= leg_d;
            landed    <= landed_d;
        end
    end

    always_comb begin
        state_d   = state;
        height_d  = height;
        hold_d    = hold_cnt;
        pending_d = pending;
        leg_d     = leg_frame;
        landed_d  = 1'b0;
        case (state)
            GROUND: begin
                if (tick) begin
                    if (pending || jump_req) begin
                        // Launch tick. The leg frame freezes from here on.
                        height_d  = FIRST_H;
                        pending_d = 1'b0;
                        hold_d    = '0;
                        state_d   = (FIRST == MAX_HEIGHT) ? HOLD : RISE;
                    end else begin
                        leg_d = ~leg_frame;
                    end
                end else if (jump_req) begin
                    // Remember a request that lands between ticks.
                    pending_d = 1'b1;
                end
            end
            RISE: begin
                if (tick) begin
                    if (rise_sum >= (HEIGHT_W+1)'(MAX_HEIGHT)) begin
                        height_d = MAX_H;
                        state_d  = HOLD;
                        hold_d   = '0;
                    end else begin
                        height_d = rise_sum[HEIGHT_W-1:0];
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hold_cnt == LAST_HOLD) state_d = FALL;
                    else                       hold_d  = hold_cnt + 1'b1;
                end
            end
            FALL: begin
                if (tick) begin
                    if (int'(height) <= FALL_STEP) begin
                        height_d = '0;
                        state_d  = GROUND;
                        landed_d = 1'b1;
                    end else begin
                        height_d = height - HEIGHT_W'(FALL_STEP);
                    end
                end
            end
            default: state_d = GROUND;
        endcase
    end

endmodule

// File: tb/tb_goose_jump_ctrl.sv
// Bench for goose_jump_ctrl. It drives two instances from the same inputs:
// one with default parameters and one with RISE_STEP=7. Each instance has an
// arithmetic reference model, and the model's expected outputs go into a
// per-instance queue. A monitor on the falling edge pops each queue and
// compares the entry against the matching DUT.
module tb_goose_jump_ctrl;

    localparam int HW   = 7;
    localparam int MAXH = 64;
    localparam int FALL = 4;
    localparam int HOLD = 4;

    logic clk_in = 1'b0;
    logic reset = 1'b1, tick = 1'b0, jump_req = 1'b0;

    logic [HW-1:0] height_a, height_b;
    logic air_a, air_b, land_a, land_b, leg_a, leg_b;

    always #5 clk_in = ~clk_in;

    goose_jump_ctrl #(.HEIGHT_W(HW), .MAX_HEIGHT(MAXH), .RISE_STEP(8),
                      .FALL_STEP(FALL), .HOLD_TICKS(HOLD)) u_dut_a (
        .clk_in(clk_in), .reset(reset), .tick(tick), .jump_req(jump_req),
        .height(height_a), .airborne(air_a), .landed(land_a), .leg_frame(leg_a));

    goose_jump_ctrl #(.HEIGHT_W(HW), .MAX_HEIGHT(MAXH), .RISE_STEP(7),
                      .FALL_STEP(FALL), .HOLD_TICKS(HOLD)) u_dut_b (
        .clk_in(clk_in), .reset(reset), .tick(tick), .jump_req(jump_req),
        .height(height_b), .airborne(air_b), .landed(land_b), .leg_frame(leg_b));

    typedef struct {
        int h;
        bit air;
        bit lnd;
        bit leg;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Model state per instance: k is the number of ticks since launch
    // (0 = on the ground).
    int k[2];
    bit pend[2], leg[2], lnd[2];
    int rstep[2];

    int checks = 0;
    int passed = 0;

    function automatic int ceil_div(int a, int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int flight_len(int rs);
        return ceil_div(MAXH, rs) + HOLD + ceil_div(MAXH, FALL);
    endfunction

    // Height after the n-th tick of a jump.
    function automatic int traj(int rs, int n);
        int nr, f, h;
        nr = ceil_div(MAXH, rs);
        if (n <= nr) begin
            h = n * rs;
            return (h > MAXH) ? MAXH : h;
        end
        if (n <= nr + HOLD) return MAXH;
        f = n - nr - HOLD;
        h = MAXH - f * FALL;
        return (h < 0) ? 0 : h;
    endfunction

    function automatic exp_t snap(int i);
        exp_t e;
        e.h   = (k[i] == 0) ? 0 : traj(rstep[i], k[i]);
        e.air = (k[i] != 0);
        e.lnd = lnd[i];
        e.leg = leg[i];
        return e;
    endfunction

    task automatic model(input bit r, input bit t, input bit j);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                k[i] = 0; pend[i] = 0; leg[i] = 0; lnd[i] = 0;
            end else begin
                lnd[i] = 0;
                if (k[i] == 0) begin
                    if (t) begin
                        if (pend[i] || j) begin
                            k[i] = 1;
                            pend[i] = 0;
                        end else begin
                            leg[i] = ~leg[i];
                        end
                    end else if (j) begin
                        pend[i] = 1;
                    end
                end else if (t) begin
                    k[i]++;
                    if (k[i] == flight_len(rstep[i])) begin
                        k[i] = 0;
                        lnd[i] = 1;
                    end
                end
            end
        end
        qa.push_back(snap(0));
        qb.push_back(snap(1));
    endtask

    // Apply inputs for one cycle. The model consumes the same values that
    // the DUT samples on this edge.
    task automatic step(input bit r, input bit t, input bit j);
        reset = r; tick = t; jump_req = j;
        @(posedge clk_in);
        model(r, t, j);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passed++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            chk("a_height",    int'(height_a), e.h);
            chk("a_airborne",  int'(air_a),    int'(e.air));
            chk("a_landed",    int'(land_a),   int'(e.lnd));
            chk("a_leg_frame", int'(leg_a),    int'(e.leg));
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            chk("b_height",    int'(height_b), e.h);
            chk("b_airborne",  int'(air_b),    int'(e.air));
            chk("b_landed",    int'(land_b),   int'(e.lnd));
            chk("b_leg_frame", int'(leg_b),    int'(e.leg));
        end
    end

    initial begin
        rstep[0] = 8;
        rstep[1] = 7;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; pend[i] = 0; leg[i] = 0; lnd[i] = 0;
        end

        // Reset state.
        step(1, 0, 0);
        step(1, 0, 0);

        // Idle running: 20 ticks with no jump request.
        for (int n = 0; n < 20; n++) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end

        // One-cycle request between ticks, then a full trajectory.
        step(0, 0, 1);
        for (int n = 0; n < 32; n++) begin
            step(0, 0, 0);
            step(0, 1, 0);
            step(0, 0, 0);
        end

        // Request held high across jumps. Nothing queues while airborne.
        for (int n = 0; n < 100; n++) step(0, (n % 3) == 0, 1);
        step(0, 0, 0);
        for (int n = 0; n < 35; n++) step(0, 1, 0);

        // Reset during HOLD on the default instance, then a normal jump.
        step(0, 1, 1);
        for (int n = 0; n < 9; n++) step(0, 1, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        for (int n = 0; n < 35; n++) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end

        // Request arriving in the same cycle as the tick.
        step(0, 1, 1);
        for (int n = 0; n < 35; n++) step(0, 1, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++)
            step(($urandom % 250) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0);

        // Let the monitor drain. The wait is bounded.
        for (int n = 0; n < 10 && (qa.size() != 0 || qb.size() != 0); n++)
            @(negedge clk_in);
        #2;
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", qa.size(), qb.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
